// File: rtl/pellet_pkg.sv
// Shared types and constants for the pellet sequencer.
// Power-pellet coordinates are only used when POWER_PELLET_EN is defined.
package pellet_pkg;

  localparam int PELLET_TOTAL_DEFAULT = 218;
  localparam int PTS_PELLET_DEFAULT   = 10;
  localparam int PTS_POWER            = 50;

  typedef logic [4:0] tile_t;
  typedef logic [2:0] state_t;

  localparam state_t ST_REFILL = 3'd0;
  localparam state_t ST_IDLE   = 3'd1;
  localparam state_t ST_ADDR   = 3'd2;
  localparam state_t ST_EVAL   = 3'd3;
  localparam state_t ST_CLEAR  = 3'd4;
  localparam state_t ST_DONE   = 3'd5;

  localparam tile_t PWR_X_LEFT  = 5'd2;
  localparam tile_t PWR_X_RIGHT = 5'd27;
  localparam tile_t PWR_Y_TOP   = 5'd4;
  localparam tile_t PWR_Y_BOT   = 5'd23;

  function automatic logic is_power_tile(input tile_t x, input tile_t y);
    return ((x == PWR_X_LEFT) || (x == PWR_X_RIGHT)) &&
           ((y == PWR_Y_TOP)  || (y == PWR_Y_BOT));
  endfunction

endpackage

// File: rtl/pellet_controller_score_accum.sv
// Score register with a saturating adder; adds points when add is high.
module score_accum #(
  parameter int SCORE_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               add,
  input  logic [SCORE_W-1:0] points,
  output logic [SCORE_W-1:0] score
);

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) score <= '0;
    else if (add) score <= sat_add(score, points);
  end

endmodule

// File: rtl/pellet_controller.sv
// Read-then-clear sequencer for the pellet bitmap port B; keeps score, remaining count
// and level. Define POWER_PELLET_EN to make the four corner tiles power pellets.
module pellet_controller
  import pellet_pkg::*;
#(
  parameter int PELLET_TOTAL = PELLET_TOTAL_DEFAULT,
  parameter int SCORE_W      = 16,
  parameter int PTS_PELLET   = PTS_PELLET_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [4:0]         req_x,
  input  logic [4:0]         req_y,
  output logic               req_ready,
  input  logic               level_restart,
  output logic [4:0]         pel_x,
  output logic [4:0]         pel_y,
  output logic               pel_clear,
  input  logic               pel_data,
  output logic               mem_reset,
  output logic               eaten,
  output logic               fright,
  output logic [SCORE_W-1:0] score,
  output logic [8:0]         remaining,
  output logic [7:0]         level,
  output logic               level_done
);

  state_t             state, state_nxt;
  tile_t              tile_x, tile_y;
  logic [SCORE_W-1:0] points;

  assign req_ready  = (state == ST_IDLE);
  assign pel_clear  = (state == ST_CLEAR);
  assign eaten      = (state == ST_CLEAR);
  assign mem_reset  = (state == ST_REFILL);
  assign level_done = (state == ST_DONE);
  assign pel_x      = tile_x;
  assign pel_y      = tile_y;

`ifdef POWER_PELLET_EN
  logic power_tile;
  assign power_tile = is_power_tile(tile_x, tile_y);
  assign fright     = pel_clear && power_tile;
  assign points     = power_tile ? SCORE_W'(PTS_POWER) : SCORE_W'(PTS_PELLET);
`else
  assign fright     = 1'b0;
  assign points     = SCORE_W'(PTS_PELLET);
`endif

  // A restart overrides every transition; CLEAR's own updates still land that cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_REFILL: state_nxt = ST_IDLE;
      ST_IDLE:   if (req_valid) state_nxt = ST_ADDR;
      ST_ADDR:   state_nxt = ST_EVAL;
      ST_EVAL:   state_nxt = pel_data ? ST_CLEAR : ST_IDLE;
      ST_CLEAR:  state_nxt = (remaining == 9'd1) ? ST_DONE : ST_IDLE;
      ST_DONE:   state_nxt = ST_REFILL;
      default:   state_nxt = ST_REFILL;
    endcase
    if (level_restart) state_nxt = ST_REFILL;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_REFILL;
      tile_x    <= '0;
      tile_y    <= '0;
      remaining <= '0;
      level     <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && req_valid) begin
        tile_x <= req_x;
        tile_y <= req_y;
      end
      if (state == ST_REFILL) remaining <= 9'(PELLET_TOTAL);
      else if (state == ST_CLEAR) remaining <= remaining - 9'd1;
      if (state == ST_DONE) level <= level + 8'd1;
    end
  end

  score_accum #(.SCORE_W(SCORE_W)) u_score (
    .clk    (clk),
    .reset  (reset),
    .add    (eaten),
    .points (points),
    .score  (score)
  );

endmodule

// File: tb/tb_pellet_controller.sv
// Bench for pellet_controller: bitmap models, a timeline model checked every cycle,
// and a second instance with a one-pellet map for the level-complete path.
module tb_pellet_controller;

  localparam int TOTAL = 218;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic       rv0, rr0, lr0, pc0, pd0, mr0, ea0, fr0, ld0;
  logic [4:0] rx0, ry0, px0, py0;
  logic [15:0] sc0;
  logic [8:0] rm0;
  logic [7:0] lv0;

  logic       rv1, rr1, lr1, pc1, pd1, mr1, ea1, fr1, ld1;
  logic [4:0] rx1, ry1, px1, py1;
  logic [15:0] sc1;
  logic [8:0] rm1;
  logic [7:0] lv1;

  pellet_controller dut (
    .clk(clk), .reset(reset), .req_valid(rv0), .req_x(rx0), .req_y(ry0),
    .req_ready(rr0), .level_restart(lr0), .pel_x(px0), .pel_y(py0),
    .pel_clear(pc0), .pel_data(pd0), .mem_reset(mr0), .eaten(ea0),
    .fright(fr0), .score(sc0), .remaining(rm0), .level(lv0), .level_done(ld0)
  );

  pellet_controller #(.PELLET_TOTAL(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(rv1), .req_x(rx1), .req_y(ry1),
    .req_ready(rr1), .level_restart(lr1), .pel_x(px1), .pel_y(py1),
    .pel_clear(pc1), .pel_data(pd1), .mem_reset(mr1), .eaten(ea1),
    .fright(fr1), .score(sc1), .remaining(rm1), .level(lv1), .level_done(ld1)
  );

  // Fresh map: every tile holds a pellet except the first four of row 0.
  function automatic bit init_pel(input int x, input int y);
    return !(y == 0 && x < 4);
  endfunction

  function automatic bit pw_tile(input int x, input int y);
`ifdef POWER_PELLET_EN
    return (x == 2 || x == 27) && (y == 4 || y == 23);
`else
    return 1'b0;
`endif
  endfunction

  bit map0 [32][32];
  bit map1 [32][32];

  always @(posedge clk) begin
    if (mr0) begin
      for (int yy = 0; yy < 32; yy++)
        for (int xx = 0; xx < 32; xx++) map0[yy][xx] <= init_pel(xx, yy);
    end else if (pc0) map0[py0][px0] <= 1'b0;
    pd0 <= map0[py0][px0];
  end

  always @(posedge clk) begin
    if (mr1) begin
      for (int yy = 0; yy < 32; yy++)
        for (int xx = 0; xx < 32; xx++) map1[yy][xx] <= init_pel(xx, yy);
    end else if (pc1) map1[py1][px1] <= 1'b0;
    pd1 <= map1[py1][px1];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: expected outputs for the current cycle plus game bookkeeping.
  bit e_ready, e_clear, e_eaten, e_fright, e_mreset, e_done;
  int e_x, e_y;
  int m_score, m_rem, m_level;
  bit m_map [32][32];
  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready",  32'(rr0), 32'(e_ready));
      chk("pel_clear",  32'(pc0), 32'(e_clear));
      chk("eaten",      32'(ea0), 32'(e_eaten));
      chk("fright",     32'(fr0), 32'(e_fright));
      chk("mem_reset",  32'(mr0), 32'(e_mreset));
      chk("level_done", 32'(ld0), 32'(e_done));
      chk("pel_x",      32'(px0), e_x);
      chk("pel_y",      32'(py0), e_y);
      chk("score",      32'(sc0), m_score);
      chk("remaining",  32'(rm0), m_rem);
      chk("level",      32'(lv0), m_level);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called while the DUT is in its refill cycle; returns in the following idle cycle.
  task automatic refill();
    e_ready  = 1'b0;
    e_mreset = 1'b1;
    step();
    e_mreset = 1'b0;
    e_ready  = 1'b1;
    m_rem    = TOTAL;
    for (int yy = 0; yy < 32; yy++)
      for (int xx = 0; xx < 32; xx++) m_map[yy][xx] = init_pel(xx, yy);
  endtask

  // rs: 0 no restart, 1 restart during ADDR, 3 restart during CLEAR.
  task automatic visit(input int x, input int y, input int rs);
    bit pw;
    int pts;
    rx0 = 5'(x);
    ry0 = 5'(y);
    rv0 = 1'b1;
    step();
    rv0 = 1'b0;
    e_ready = 1'b0;
    e_x = x;
    e_y = y;
    if (rs == 1) begin
      lr0 = 1'b1;
      step();
      lr0 = 1'b0;
      refill();
      return;
    end
    step();
    if (!m_map[y][x]) begin
      step();
      e_ready = 1'b1;
      return;
    end
    step();
    pw = pw_tile(x, y);
    pts = pw ? 50 : 10;
    e_clear  = 1'b1;
    e_eaten  = 1'b1;
    e_fright = pw;
    if (rs == 3) lr0 = 1'b1;
    step();
    lr0 = 1'b0;
    e_clear  = 1'b0;
    e_eaten  = 1'b0;
    e_fright = 1'b0;
    m_score  = (m_score + pts > 65535) ? 65535 : m_score + pts;
    m_rem    = m_rem - 1;
    m_map[y][x] = 1'b0;
    if (rs == 3) begin
      refill();
    end else if (m_rem == 0) begin
      e_done = 1'b1;
      step();
      e_done  = 1'b0;
      m_level = (m_level + 1) % 256;
      refill();
    end else begin
      e_ready = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    rv0 = 1'b0; lr0 = 1'b0; rx0 = '0; ry0 = '0;
    rv1 = 1'b0; lr1 = 1'b0; rx1 = '0; ry1 = '0;
    e_ready = 1'b0; e_clear = 1'b0; e_eaten = 1'b0; e_fright = 1'b0;
    e_mreset = 1'b1; e_done = 1'b0; e_x = 0; e_y = 0;
    m_score = 0; m_rem = 0; m_level = 0;
    for (int yy = 0; yy < 32; yy++)
      for (int xx = 0; xx < 32; xx++) m_map[yy][xx] = init_pel(xx, yy);
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rel_mreset", 32'(mr0), 32'd1);
    chk("rel_rem",    32'(rm0), 32'd0);
    refill();
    chk("init_rem",   32'(rm0), 32'd218);
    chk("init_ready", 32'(rr0), 32'd1);
    chk("init_mreset", 32'(mr0), 32'd0);

    visit(5, 2, 0);
    chk("hit_score", 32'(sc0), 32'd10);
    chk("hit_rem",   32'(rm0), 32'd217);
    visit(5, 2, 0);
    chk("rep_score", 32'(sc0), 32'd10);
    visit(0, 0, 0);
    chk("empty_rem", 32'(rm0), 32'd217);

    visit(2, 4, 0);
`ifdef POWER_PELLET_EN
    chk("power_score", 32'(sc0), 32'd60);
`else
    chk("power_score", 32'(sc0), 32'd20);
`endif
    chk("power_rem", 32'(rm0), 32'd216);

    visit(7, 7, 1);
    chk("rs_addr_rem",   32'(rm0), 32'd218);
    chk("rs_addr_level", 32'(lv0), 32'd0);
    visit(8, 8, 3);
    chk("rs_clear_rem", 32'(rm0), 32'd218);
    visit(5, 2, 0);
`ifdef POWER_PELLET_EN
    chk("refilled_score", 32'(sc0), 32'd80);
`else
    chk("refilled_score", 32'(sc0), 32'd40);
`endif
    chk("refilled_rem", 32'(rm0), 32'd217);

    chk("t1_rem_init", 32'(rm1), 32'd1);
    rx1 = 5'd5; ry1 = 5'd2; rv1 = 1'b1;
    step();
    rv1 = 1'b0;
    step();
    step();
    chk("t1_eaten",  32'(ea1), 32'd1);
    chk("t1_clear",  32'(pc1), 32'd1);
    chk("t1_fright", 32'(fr1), 32'd0);
    step();
    chk("t1_done",      32'(ld1), 32'd1);
    chk("t1_rem_zero",  32'(rm1), 32'd0);
    chk("t1_score",     32'(sc1), 32'd10);
    chk("t1_level_pre", 32'(lv1), 32'd0);
    step();
    chk("t1_mreset", 32'(mr1), 32'd1);
    chk("t1_level",  32'(lv1), 32'd1);
    chk("t1_done_off", 32'(ld1), 32'd0);
    step();
    chk("t1_rem_reload", 32'(rm1), 32'd1);
    chk("t1_ready",      32'(rr1), 32'd1);

    step();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pellet_controller.md
# pellet_controller

Sequencer for the 32×32 pellet bitmap. It accepts tile-visit requests from the player movement logic and drives the bitmap's read/clear port (port B) with a read-then-clear sequence. It keeps the score, the remaining-pellet count and the level number, and refills the map when a level completes or a restart is requested. It sits between player movement and the pellet memory; the video renderer keeps exclusive use of port A.

## Interface
- PELLET_TOTAL, 218, pellets in a freshly loaded map; reload value of the remaining count
- SCORE_W, 16, score width
- PTS_PELLET, 10, points per normal pellet
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  player has entered tile (req_x, req_y)
- req_x  in  5  tile column
- req_y  in  5  tile row
- req_ready  out  1  request accepted when req_valid && req_ready
- level_restart  in  1  level-refill request (e.g. after death); single-cycle pulse
- pel_x  out  5  port-B column to the bitmap
- pel_y  out  5  port-B row to the bitmap
- pel_clear  out  1  port-B clear strobe
- pel_data  in  1  port-B registered read data; valid the cycle after the address
- mem_reset  out  1  synchronous refill strobe to the bitmap
- eaten  out  1  one-cycle pulse: a pellet was consumed
- fright  out  1  one-cycle pulse: a power pellet was consumed
- score  out  SCORE_W  accumulated points
- remaining  out  9  pellets left on the map
- level  out  8  current level number
- level_done  out  1  one-cycle pulse: map emptied

## Operation
- FSM states: REFILL, IDLE, ADDR, EVAL, CLEAR, DONE.
- REFILL:
  - mem_reset=1 and remaining<=PELLET_TOTAL.
  - Next state is IDLE.
- IDLE:
  - req_ready=1.
  - On accept, latch x/y and go to ADDR.
- ADDR:
  - pel_x/pel_y = latched tile and pel_clear=0; the bitmap samples the address on this cycle's edge.
  - Next state is EVAL.
- EVAL:
  - pel_data is valid in this state.
  - If pel_data=1, go to CLEAR; otherwise go to IDLE with no side effects.
- CLEAR:
  - pel_clear=1 with the same address, and eaten=1.
  - At the end of the cycle: score += points (saturating at all-ones) and remaining -= 1.
  - If the new remaining value is 0, go to DONE; otherwise go to IDLE.
- DONE:
  - level_done=1 and level += 1 (8-bit, wraps 255→0).
  - Next state is REFILL.
- pel_x/pel_y hold the latched tile in every state. pel_clear is 1 only in CLEAR. mem_reset is 1 only in REFILL.
- level_restart is honoured in any state:
  - Next state is REFILL, and any in-flight sequence is aborted; no clear is issued and nothing is scored.
  - Score and level are unchanged.
  - If it coincides with CLEAR, the clear and score update of that cycle still complete, then the FSM goes to REFILL instead of IDLE or DONE.
- remaining never underflows. A CLEAR with remaining=0 cannot occur, because REFILL always precedes IDLE.
- req_valid seen while req_ready=0 is not consumed; the requester holds it.

## Timing
- Reset values:
  - State is REFILL, so mem_reset=1 during reset and for the first cycle after release.
  - score=0, level=0, remaining=0 until REFILL completes.
  - All pulses=0, req_ready=0, pel_clear=0, pel_x=pel_y=0.
- Request accepted at cycle T:
  - ADDR at T+1, EVAL at T+2.
  - On a miss, req_ready=1 again at T+3.
  - On a hit, CLEAR is at T+3, eaten pulses at T+3, and score/remaining update at T+4.
  - On a hit that empties the map: level_done at T+4, REFILL at T+5, IDLE at T+6.
- Throughput is 3 cycles per miss and 4 per hit.

## Configuration
- POWER_PELLET_EN defined:
  - Tiles (2,4), (27,4), (2,23), (27,23) are power pellets.
  - Consuming one scores PTS_POWER (50) and pulses fright with eaten in CLEAR.
- POWER_PELLET_EN undefined:
  - Every pellet scores PTS_PELLET.
  - fright is tied to 0; the port remains so the interface is identical.

## Structure
- Package pellet_pkg holds:
  - the state enum;
  - the PELLET_TOTAL default;
  - PTS_PELLET and PTS_POWER;
  - the four power-pellet coordinates;
  - the 5-bit tile coordinate type.
- One sub-module, score_accum: saturating adder plus register for score, fed by a points value and an add strobe.

## Test plan
- Reset release → mem_reset high for exactly one cycle after release, then remaining=218, req_ready=1, score=0.
- Request (5,2) on a fresh map → pel_clear high at T+3 at (5,2), eaten pulse, score=10, remaining=217. Repeating the same tile → miss and score stays 10.
- Request (0,0) (empty tile) → pel_clear never asserts, req_ready returns at T+3, counts unchanged.
- Preset PELLET_TOTAL=1, eat one pellet → level_done at T+4, level=1, mem_reset at T+5, remaining=1.
- level_restart asserted during ADDR → no clear issued, REFILL next cycle, score and level held, remaining=PELLET_TOTAL.
- With POWER_PELLET_EN, request (2,4) → eaten and fright together, score +50. Without it → score +10 and fright stays 0.
